cargador_programa: RTL and testbench
====================================

CARGADOR_PROGRAMA -- requirements
Module: cargador_programa

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 32, instruction word width in bits.
REQ-002 SHALL have parameter RAM_DEPTH, default 2048, number of program-memory words.
REQ-003 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, the end-of-program instruction.
REQ-004 SHALL have localparam AW = clogb2(RAM_DEPTH) (11 by default), the address width.
REQ-005 SHALL have i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have i_reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have i_start, input, 1, one-cycle pulse that starts a load.
REQ-008 SHALL have i_rx_data, input, 8, received byte.
REQ-009 SHALL have i_rx_valid, input, 1, one-cycle strobe marking i_rx_data valid.
REQ-010 SHALL have i_reset_ack, input, 1, clear-progress flag from program memory; 1 = clearing, 0 = clear finished.
REQ-011 SHALL have o_addr, output, AW, program-memory write address.
REQ-012 SHALL have o_data, output, RAM_WIDTH, program-memory write data.
REQ-013 SHALL have o_ena and o_wea, outputs, 1 each, memory enable and write enable.
REQ-014 SHALL have o_soft_reset, output, 1, active-low memory clear request.
REQ-015 SHALL have o_busy, o_done and o_error, outputs, 1 each, load status.
REQ-016 SHALL have o_word_count, output, AW+1, number of words written in the current load.

Function
REQ-017 SHALL implement the states IDLE, CLEAR, RECV, WRITE and DONE.
REQ-018 IDLE or DONE + i_start SHALL go to CLEAR on the next edge; this clears o_done, o_error, o_word_count, the word pointer and the byte counter.
REQ-019 i_start in CLEAR, RECV or WRITE SHALL be ignored.
REQ-020 CLEAR SHALL drive o_soft_reset=0 for at least 2 cycles, then move to RECV on the first cycle where i_reset_ack==0, releasing o_soft_reset to 1.
REQ-021 In RECV, each i_rx_valid SHALL shift its byte into the word big-endian: the first byte lands in [31:24], the fourth in [7:0]; the 2-bit byte counter wraps 3->0.
REQ-022 The fourth byte SHALL cause a transition to WRITE on the next edge.
REQ-023 WRITE SHALL last exactly 1 cycle, with o_ena=1, o_wea=1, o_addr=pointer and o_data=assembled word.
REQ-024 Leaving WRITE SHALL increment the pointer and o_word_count.
REQ-025 On leaving WRITE, a word equal to HALT_WORD SHALL go to DONE.
REQ-026 Otherwise, a pointer that wraps to 0 (RAM_DEPTH words written) SHALL go to DONE with o_error=1.
REQ-027 Otherwise, leaving WRITE SHALL go to RECV.
REQ-028 An i_rx_valid during WRITE SHALL be accepted as byte 0 of the next word; no byte is ever dropped.
REQ-029 i_rx_valid in IDLE, CLEAR or DONE SHALL be ignored.
REQ-030 o_ena and o_wea SHALL be 0 outside WRITE; the memory is never read by this block.
REQ-031 o_busy SHALL be 1 in CLEAR, RECV and WRITE.
REQ-032 o_done SHALL be 1 in DONE and hold until the next i_start.
REQ-033 o_error SHALL hold until the next i_start.
REQ-034 All outputs SHALL be registered, except that o_soft_reset, o_busy and o_ena/o_wea may decode the current state.

Reset
REQ-035 i_reset=0 SHALL asynchronously force state IDLE.
REQ-036 Reset SHALL force pointer, byte counter, o_addr, o_data and o_word_count to 0.
REQ-037 Reset SHALL force o_ena, o_wea, o_busy, o_done and o_error to 0, and o_soft_reset to 1.
REQ-038 Reset mid-load SHALL abandon the partial word with no further memory write; memory contents are unaffected.

Structure
REQ-039 The state encoding and the HALT_WORD default SHALL live in the shared package cargador_pkg, along with clogb2 and the byte-order constant.
REQ-040 The byte-to-word shifter and byte counter SHALL be the sub-module empaquetador_palabra (i_clk, i_reset, i_clear, i_byte, i_valid, o_word, o_word_valid).

Verification
REQ-041 Start; ack drops 5 cycles into CLEAR; send 12 34 56 78 then FF FF FF FF -> writes 0x12345678@0 and 0xFFFFFFFF@1; o_done=1, o_word_count=2, o_error=0.
REQ-042 Send 2048 non-halt words -> the 2048th write goes to address 2047; DONE with o_error=1 and o_word_count=2048.
REQ-043 Send byte 0xAA exactly in the WRITE cycle of word 0 -> word 1 begins with 0xAA in [31:24]; no byte lost.
REQ-044 Assert i_reset after 2 bytes of word 3 -> IDLE, all outputs at reset values, no further o_wea pulse; a new start reloads from address 0.
REQ-045 Pulse i_start during RECV, and send i_rx_valid during CLEAR and DONE -> no state, pointer or count change.
REQ-046 Hold i_reset_ack=1 for 100 cycles -> stays in CLEAR with o_soft_reset=0 throughout; moves to RECV 1 cycle after ack falls.

Source files
------------

// File: rtl/cargador_pkg.sv
// cargador_pkg: loader states, halt word, byte order and address-width helper
package cargador_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RECV, S_WRITE, S_DONE} state_t;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam bit BYTE_MSB_FIRST = 1'b1;
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/empaquetador_palabra.sv
// empaquetador_palabra: shifts received bytes into a word and flags the last byte
module empaquetador_palabra
  import cargador_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic [7:0]   i_byte,
  input  logic         i_valid,
  output logic [W-1:0] o_word,
  output logic         o_word_valid
);
  localparam int NB = W / 8;
  localparam int CW = clogb2(NB);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  word_q, word_d;
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (i_clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (i_valid) begin
      word_d = BYTE_MSB_FIRST ? {word_q[W-9:0], i_byte} : {i_byte, word_q[W-1:8]};
      cnt_d  = (cnt_q == CW'(NB - 1)) ? '0 : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end
  // o_word already includes the byte being accepted so the caller can latch it this cycle
  assign o_word       = word_d;
  assign o_word_valid = !i_clear && i_valid && (cnt_q == CW'(NB - 1));
endmodule

// File: rtl/cargador_programa.sv
// cargador_programa: loads a byte stream into program memory until halt word or memory full
module cargador_programa
  import cargador_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 2048,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD = HALT_WORD_DEFAULT,
  localparam int AW = clogb2(RAM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  input  logic                 i_reset_ack,
  output logic [AW-1:0]        o_addr,
  output logic [RAM_WIDTH-1:0] o_data,
  output logic                 o_ena,
  output logic                 o_wea,
  output logic                 o_soft_reset,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [AW:0]          o_word_count
);
  state_t               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [RAM_WIDTH-1:0] data_q, data_d;
  logic                 done_q, done_d, error_q, error_d, clr_q, clr_d;
  logic                 start, last, halt, word_valid;
  logic [RAM_WIDTH-1:0] word;
  assign start = i_start && (state_q == S_IDLE || state_q == S_DONE);
  assign last  = ptr_q == AW'(RAM_DEPTH - 1);
  assign halt  = data_q == HALT_WORD;
  empaquetador_palabra #(.W(RAM_WIDTH)) u_pack (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (start),
    .i_byte       (i_rx_data),
    .i_valid      (i_rx_valid && (state_q == S_RECV || state_q == S_WRITE)),
    .o_word       (word),
    .o_word_valid (word_valid)
  );
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;
    // clr_q marks the second and later CLEAR cycles, guaranteeing a two-cycle minimum clear
    clr_d   = state_q == S_CLEAR;
    if (start) begin
      state_d = S_CLEAR;
      ptr_d   = '0;
      count_d = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else if (state_q == S_CLEAR && clr_q && !i_reset_ack) begin
      state_d = S_RECV;
    end else if (state_q == S_RECV && word_valid) begin
      state_d = S_WRITE;
      data_d  = word;
    end else if (state_q == S_WRITE) begin
      ptr_d   = last ? '0 : ptr_q + 1'b1;
      count_d = count_q + 1'b1;
      state_d = (halt || last) ? S_DONE : S_RECV;
      done_d  = halt || last;
      error_d = !halt && last;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      clr_q   <= clr_d;
    end
  end
  assign o_addr       = ptr_q;
  assign o_data       = data_q;
  assign o_ena        = state_q == S_WRITE;
  assign o_wea        = state_q == S_WRITE;
  assign o_soft_reset = state_q != S_CLEAR;
  assign o_busy       = state_q == S_CLEAR || state_q == S_RECV || state_q == S_WRITE;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_word_count = count_q;
endmodule

// File: tb/tb_cargador_programa.sv
// tb_cargador_programa: randomized byte streams checked against a word-level loader model
module tb_cargador_programa;
  logic        i_clk = 1'b0, i_reset = 1'b0, i_start = 1'b0, i_rx_valid = 1'b0, i_reset_ack = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic [10:0] o_addr;
  logic [31:0] o_data;
  logic        o_ena, o_wea, o_soft_reset, o_busy, o_done, o_error;
  logic [11:0] o_word_count;
  int          errors = 0, checks = 0;
  logic [42:0] obs_q[$], exp_q[$];
  logic [7:0]  stim[$];
  int          exp_words;
  bit          exp_done, exp_err;
  cargador_programa dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .i_reset_ack(i_reset_ack), .o_addr(o_addr), .o_data(o_data),
    .o_ena(o_ena), .o_wea(o_wea), .o_soft_reset(o_soft_reset), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_word_count(o_word_count)
  );
  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (o_wea) obs_q.push_back({o_addr, o_data});
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, " addr"}, o_addr, 0);
    chk({tag, " data"}, o_data, 0);
    chk({tag, " count"}, o_word_count, 0);
    chk({tag, " ena"}, o_ena, 0);
    chk({tag, " wea"}, o_wea, 0);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " done"}, o_done, 0);
    chk({tag, " error"}, o_error, 0);
    chk({tag, " soft_reset"}, o_soft_reset, 1);
  endtask
  // Memory clear takes max(2, ack cycles) with junk bytes offered that must be ignored
  task automatic start_load(input int ack_cycles);
    int m, bad;
    obs_q.delete();
    i_reset_ack = ack_cycles > 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start busy", o_busy, 1);
    chk("start done cleared", o_done, 0);
    chk("start error cleared", o_error, 0);
    chk("start count cleared", o_word_count, 0);
    m = ack_cycles > 1 ? ack_cycles : 1;
    bad = 0;
    for (int k = 0; k <= m; k++) begin
      i_reset_ack = k < ack_cycles;
      i_rx_data = 8'($urandom);
      i_rx_valid = 1'($urandom);
      if (o_soft_reset !== 1'b0) bad++;
      tick();
    end
    i_rx_valid = 1'b0;
    i_reset_ack = 1'b0;
    chk("clear soft_reset low cycles", bad, 0);
    chk("recv soft_reset released", o_soft_reset, 1);
    chk("recv busy", o_busy, 1);
  endtask
  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) stim.push_back(8'(w >> (8 * b)));
  endtask
  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    return (w == 32'hFFFF_FFFF) ? 32'h0 : w;
  endfunction
  task automatic send(input int gapmax);
    foreach (stim[i]) begin
      i_rx_data = stim[i];
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
      tick($urandom_range(gapmax));
    end
    tick(4);
  endtask
  // Reference: every 4 bytes form one big-endian word written to the next address
  function automatic void model();
    logic [31:0] w;
    exp_q.delete();
    exp_words = 0;
    exp_done = 0;
    exp_err = 0;
    for (int i = 0; i + 3 < stim.size() && !exp_done; i += 4) begin
      w = (32'(stim[i]) << 24) + (32'(stim[i+1]) << 16) + (32'(stim[i+2]) << 8) + 32'(stim[i+3]);
      exp_q.push_back({11'(exp_words % 2048), w});
      exp_words++;
      if (w == 32'hFFFF_FFFF) exp_done = 1;
      else if (exp_words == 2048) begin
        exp_done = 1;
        exp_err = 1;
      end
    end
  endfunction
  task automatic compare_writes(input string tag);
    chk({tag, " write count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s write %0d", tag, i), obs_q[i], exp_q[i]);
  endtask
  task automatic compare_status(input string tag);
    chk({tag, " word_count"}, o_word_count, exp_words);
    chk({tag, " done"}, o_done, exp_done);
    chk({tag, " error"}, o_error, exp_err);
    chk({tag, " busy"}, o_busy, !exp_done);
    chk({tag, " wea idle"}, o_wea, 0);
  endtask
  initial begin
    tick(2);
    check_reset("reset");
    i_reset = 1'b1;
    tick();
    // Basic load with ack dropping 5 cycles into clear
    stim.delete();
    push_word(32'h1234_5678);
    push_word(32'hFFFF_FFFF);
    start_load(5);
    send(2);
    model();
    compare_writes("basic");
    compare_status("basic");
    chk("basic first write", obs_q.size() > 0 ? obs_q[0] : 43'h0, {11'd0, 32'h1234_5678});
    // Byte arriving in the WRITE cycle becomes byte 0 of the next word
    stim.delete();
    push_word(rand_word());
    push_word({8'hAA, 24'($urandom)});
    push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    start_load(0);
    send(0);
    model();
    compare_writes("write-cycle byte");
    compare_status("write-cycle byte");
    chk("write-cycle byte top", obs_q.size() > 1 ? obs_q[1][31:24] : 8'h0, 8'hAA);
    // Start pulse during RECV and bytes during DONE are ignored
    stim.delete();
    push_word(rand_word());
    start_load(3);
    send(1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("recv start ignored count", o_word_count, 1);
    chk("recv start ignored soft_reset", o_soft_reset, 1);
    chk("recv start ignored busy", o_busy, 1);
    push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    stim = stim[4:$];
    send(2);
    stim = {8'h00, 8'h00, 8'h00, 8'h00};
    send(0);
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back(8'h00);
    exp_q.delete();
    exp_words = 3;
    exp_done = 1;
    exp_err = 0;
    chk("done bytes ignored writes", obs_q.size(), 3);
    compare_status("done bytes ignored");
    chk("ignored-start word 1 addr", obs_q.size() > 1 ? obs_q[1][42:32] : 11'h7FF, 1);
    // Long ack keeps the block in clear
    stim.delete();
    push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    start_load(100);
    send(2);
    model();
    compare_writes("long ack");
    compare_status("long ack");
    // Full memory without a halt word ends in error at address 2047
    stim.delete();
    for (int i = 0; i < 2049; i++) push_word(rand_word());
    start_load(2);
    send(0);
    model();
    compare_writes("overflow");
    compare_status("overflow");
    chk("overflow last addr", obs_q.size() > 0 ? obs_q[$][42:32] : 11'h0, 11'd2047);
    // Reset after two bytes of word 3 abandons the partial word
    stim.delete();
    for (int i = 0; i < 3; i++) push_word(rand_word());
    stim.push_back(8'($urandom));
    stim.push_back(8'($urandom));
    start_load(2);
    foreach (stim[i]) begin
      i_rx_data = stim[i];
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
    end
    #2 i_reset = 1'b0;
    #1 check_reset("async reset");
    tick(3);
    i_reset = 1'b1;
    tick(6);
    model();
    compare_writes("reset abandon");
    check_reset("after reset");
    stim.delete();
    push_word(rand_word());
    push_word(32'hFFFF_FFFF);
    start_load(1);
    send(2);
    model();
    compare_writes("reload");
    compare_status("reload");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
